// File: rtl/cnn_mnist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_mnist_pkg
// Description : Shared constants and types for the MNIST CNN input path.
//               Image geometry, pixel width, BRAM word size and the state
//               type used by the image BRAM reader.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_mnist_pkg;

  localparam int unsigned PIX_W           = 8;
  localparam int unsigned MNIST_IMG_W     = 28;
  localparam int unsigned MNIST_IMG_H     = 28;
  localparam int unsigned BRAM_WORD_BYTES = 4;
  localparam int unsigned BRAM_DATA_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/bram_rd_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bram_rd_skid_fifo
// Description : Two-entry, 32-bit word FIFO that absorbs BRAM read returns
//               while the pixel unpacker is stalled.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               flush           - synchronous clear to empty
//               push, din       - write one word
//               pop, dout       - drop the head word / head word value
//               full, empty     - occupancy flags
//               count           - number of stored words (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module bram_rd_skid_fifo (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        push,
  input  logic [31:0] din,
  input  logic        pop,
  output logic [31:0] dout,
  output logic        full,
  output logic        empty,
  output logic [1:0]  count
);

  logic [31:0] mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  cnt;
  logic        do_push;
  logic        do_pop;

  // Guard both ends so a misbehaving producer/consumer cannot corrupt count.
  assign do_push = push && (cnt != 2'd2);
  assign do_pop  = pop && (cnt != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed when count != 0.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);
  assign count = cnt;

endmodule
`default_nettype wire

// File: rtl/input_image_bram_reader.sv
`default_nettype none
// ============================================================================
// Module      : input_image_bram_reader
// Description : Streams one image out of a 32-bit BRAM (4 pixels per word,
//               byte 0 first) as a valid/ready pixel stream with row and
//               frame markers.
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               start, abort        - image request / synchronous flush
//               busy, done          - activity flag / end-of-image pulse
//               BRAM_PORTB_0_*      - read-only BRAM port (we/din tied off)
//               pix_data/valid/ready- pixel stream handshake
//               pix_last, row_last  - final pixel / last column markers
// Revision    : 1.0 - initial release
// ============================================================================
module input_image_bram_reader
  import cnn_mnist_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned IMG_W     = MNIST_IMG_W,
  parameter int unsigned IMG_H     = MNIST_IMG_H
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             BRAM_PORTB_0_clk,
  output logic [31:0]      BRAM_PORTB_0_addr,
  output logic             BRAM_PORTB_0_en,
  output logic [3:0]       BRAM_PORTB_0_we,
  output logic [31:0]      BRAM_PORTB_0_din,
  input  logic [31:0]      BRAM_PORTB_0_dout,
  output logic [PIX_W-1:0] pix_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             pix_last,
  output logic             row_last
);

  localparam int unsigned NUM_WORDS = (IMG_W * IMG_H) / BRAM_WORD_BYTES;
  localparam int unsigned RD_W      = $clog2(NUM_WORDS + 1);
  localparam int unsigned COL_W     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W     = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [RD_W-1:0]  RD_END  = RD_W'(NUM_WORDS);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

  rd_state_e        state;
  rd_state_e        state_nxt;
  logic [RD_W-1:0]  rd_cnt;
  logic             rd_inflight;
  logic [1:0]       byte_idx;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  logic             run;
  logic             hs;
  logic [2:0]       occupancy;
  logic             fifo_flush;
  logic             fifo_pop;
  logic [31:0]      fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [1:0]       fifo_count;

  assign run = (state == ST_RUN);

  // Credit check counts reads still in flight so a return always has a slot.
  assign occupancy = {1'b0, fifo_count} + {2'b00, rd_inflight};

  assign BRAM_PORTB_0_clk  = clk;
  assign BRAM_PORTB_0_we   = 4'b0000;
  assign BRAM_PORTB_0_din  = 32'h0000_0000;
  assign BRAM_PORTB_0_en   = run && !abort && !fifo_full &&
                             (rd_cnt != RD_END) && (occupancy < 3'd2);
  assign BRAM_PORTB_0_addr = BASE_ADDR + (32'(rd_cnt) * BRAM_WORD_BYTES);

  assign pix_valid = run && !fifo_empty;
  assign pix_data  = pix_valid ? fifo_dout[{byte_idx, 3'b000} +: PIX_W] : '0;
  assign row_last  = pix_valid && (col == COL_MAX);
  assign pix_last  = row_last && (row == ROW_MAX);
  assign hs        = pix_valid && pix_ready;

  // Leaving RUN for any reason drops whatever is buffered.
  assign fifo_flush = abort || !run;
  assign fifo_pop   = hs && (byte_idx == 2'd3);

  bram_rd_skid_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (fifo_flush),
    .push  (rd_inflight),
    .din   (BRAM_PORTB_0_dout),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rd_cnt      <= '0;
      rd_inflight <= 1'b0;
      byte_idx    <= 2'd0;
      col         <= '0;
      row         <= '0;
    end else begin
      state <= state_nxt;
      if (abort || !run) begin
        // Clearing rd_inflight discards a read return still on its way.
        rd_cnt      <= '0;
        rd_inflight <= 1'b0;
        byte_idx    <= 2'd0;
        col         <= '0;
        row         <= '0;
      end else begin
        rd_inflight <= BRAM_PORTB_0_en;
        if (BRAM_PORTB_0_en) rd_cnt <= rd_cnt + 1'b1;
        if (hs) begin
          byte_idx <= byte_idx + 2'd1;
          if (row_last) begin
            col <= '0;
            row <= pix_last ? '0 : row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (hs && pix_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = !abort;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

endmodule
`default_nettype wire

// File: tb/tb_input_image_bram_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_image_bram_reader
// Description : Self-checking bench for input_image_bram_reader with a BRAM
//               model, pixel scoreboard and bus monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_image_bram_reader;
  import cnn_mnist_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int NPIX   = 784;
  localparam int NWORDS = 196;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        pix_ready = 1'b0;
  logic        busy, done, bclk, en;
  logic [31:0] addr, bdin;
  logic [31:0] bdout = 32'h0;
  logic [3:0]  we;
  logic [7:0]  pix_data;
  logic        pix_valid, pix_last, row_last;

  always #5 clk = ~clk;

  input_image_bram_reader dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .abort             (abort),
    .busy              (busy),
    .done              (done),
    .BRAM_PORTB_0_clk  (bclk),
    .BRAM_PORTB_0_addr (addr),
    .BRAM_PORTB_0_en   (en),
    .BRAM_PORTB_0_we   (we),
    .BRAM_PORTB_0_din  (bdin),
    .BRAM_PORTB_0_dout (bdout),
    .pix_data          (pix_data),
    .pix_valid         (pix_valid),
    .pix_ready         (pix_ready),
    .pix_last          (pix_last),
    .row_last          (row_last)
  );

  // ---------------- BRAM model: one-cycle read latency ----------------
  logic [31:0] bram [NWORDS];
  always @(posedge clk) begin
    if (en) begin
      if (((addr - BASE) >> 2) < NWORDS) bdout <= bram[(addr - BASE) >> 2];
      else bdout <= 32'hDEAD_BEEF;
    end
  end

  // ---------------- counters and check helper ----------------
  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
  endtask

  // ---------------- pixel ready driver ----------------
  int ready_pct = 100;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      pix_ready = (int'($urandom_range(0, 99)) < ready_pct);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       rl;
  } pix_t;

  pix_t exp_q[$];

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit         mon_on = 1'b0;
  int         en_cnt, pix_cnt, rl_cnt, last_cnt, done_cnt, done_cyc;
  int         first_valid_cyc, first_hs, last_hs, max_out, stable_err;
  logic       prev_valid, prev_ready, prev_last, prev_rl;
  logic [7:0] prev_data;

  task automatic clear_mon();
    en_cnt = 0; pix_cnt = 0; rl_cnt = 0; last_cnt = 0; done_cnt = 0;
    done_cyc = -1; first_valid_cyc = -1; first_hs = -1; last_hs = -1;
    max_out = 0; stable_err = 0;
  endtask

  always @(negedge clk) begin
    pix_t e;
    int   outst;
    if (mon_on) begin
      if (en) begin
        check("bram_addr", addr, BASE + 32'(en_cnt * 4));
        en_cnt++;
      end
      if (pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_valid && !prev_ready &&
          (!pix_valid || pix_data !== prev_data || pix_last !== prev_last || row_last !== prev_rl))
        stable_err++;
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL scoreboard_empty: got pixel 0x%0h, expected no more pixels", pix_data);
        end else begin
          e = exp_q.pop_front();
          check("pixel", {pix_data, pix_last, row_last}, {e.data, e.last, e.rl});
        end
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        pix_cnt++;
        if (row_last) rl_cnt++;
        if (pix_last) last_cnt++;
      end
      outst = en_cnt - pix_cnt / 4;
      if (outst > max_out) max_out = outst;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    prev_valid = pix_valid;
    prev_ready = pix_ready;
    prev_data  = pix_data;
    prev_last  = pix_last;
    prev_rl    = row_last;
  end

  task automatic load_expected();
    pix_t e;
    exp_q.delete();
    for (int p = 0; p < NPIX; p++) begin
      e.data = 8'(p / 4) + 8'(p % 4);
      e.last = (p == NPIX - 1);
      e.rl   = ((p % 28) == 27);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start(output int sc);
    @(posedge clk);
    #2 start = 1'b1;
    sc = cyc + 1;
    @(posedge clk);
    #2 start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {busy, done, en, addr, pix_valid, pix_data, pix_last, row_last},
          {3'b000, BASE, 1'b0, 8'h00, 2'b00});
  endtask

  // Start an image and wait until the monitor has seen at least n handshakes.
  task automatic start_and_wait(input int n);
    int sc;
    int t;
    clear_mon();
    load_expected();
    ready_pct = 100;
    mon_on = 1'b1;
    pulse_start(sc);
    t = 0;
    while (pix_cnt < n && t < 4000) begin
      @(posedge clk);
      #2 t++;
    end
    check("partial_progress_reached", 64'(pix_cnt >= n), 64'd1);
  endtask

  task automatic run_image(input int pct, input int extra_at, input int stall);
    int sc;
    int t;
    bit extra_sent;
    extra_sent = 1'b0;
    clear_mon();
    load_expected();
    ready_pct = (stall > 0) ? 0 : pct;
    mon_on = 1'b1;
    pulse_start(sc);
    t = 1;
    while (done_cnt == 0 && t < 8000) begin
      @(posedge clk);
      #2 t++;
      if (stall > 0 && t == stall) begin
        check("stall_en_count", en_cnt, 2);
        check("stall_valid_held", pix_valid, 1'b1);
        check("stall_pix_data", pix_data, 8'h00);
        ready_pct = pct;
      end
      if (extra_at >= 0 && !extra_sent && pix_cnt >= extra_at) begin
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        t++;
        extra_sent = 1'b1;
        check("busy_during_extra_start", busy, 1'b1);
      end
    end
    check("image_done_within_budget", 64'(done_cnt > 0), 64'd1);
    repeat (3) @(posedge clk);
    #2;
    check("pixel_count", pix_cnt, NPIX);
    check("read_count", en_cnt, NWORDS);
    check("row_last_pulses", rl_cnt, 28);
    check("pix_last_pulses", last_cnt, 1);
    check("done_pulses", done_cnt, 1);
    check("done_after_last", done_cyc, last_hs + 1);
    check("max_words_buffered_le2", 64'(max_out <= 2), 64'd1);
    check("first_valid_latency_le3", 64'(first_valid_cyc - sc <= 3), 64'd1);
    check("scoreboard_drained", exp_q.size(), 0);
    check("stable_while_stalled", stable_err, 0);
    check("idle_after_done", {busy, pix_valid, en}, 3'b000);
    if (pct == 100 && stall == 0) check("throughput_1ppc", last_hs - first_hs, NPIX - 1);
    mon_on = 1'b0;
  endtask

  // ---------------- scenario table ----------------
  typedef struct {
    int pct;
    int extra_at;
    int stall;
  } scen_t;

  scen_t tbl[5];

  initial begin
    int seen;
    for (int k = 0; k < NWORDS; k++) begin
      logic [7:0] k8;
      k8 = 8'(k);
      bram[k] = {k8 + 8'd3, k8 + 8'd2, k8 + 8'd1, k8};
    end
    tbl[0] = '{100, -1,   0};
    tbl[1] = '{ 50, -1,   0};
    tbl[2] = '{100, 100,  0};
    tbl[3] = '{100, -1, 100};
    tbl[4] = '{ 35, 400,  0};
    clear_mon();

    // Reset state
    #1 check_reset_outputs("reset_outputs");
    check("bram_we_din", {we, bdin}, 36'h0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset_outputs");
    check("bram_clk_low", bclk, 1'b0);
    @(posedge clk);
    #1 check("bram_clk_high", bclk, 1'b1);

    // Table-driven full images (back-to-back starts right after DONE)
    for (int i = 0; i < 5; i++) run_image(tbl[i].pct, tbl[i].extra_at, tbl[i].stall);

    // Abort at pixel 300
    start_and_wait(300);
    @(posedge clk);
    #2 abort = 1'b1;
    mon_on = 1'b0;
    @(posedge clk);
    #2 abort = 1'b0;
    check("abort_flush", {busy, pix_valid, en}, 3'b000);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen += int'(done) + int'(pix_valid);
    end
    check("abort_no_done", seen, 0);
    run_image(100, -1, 0);

    // start and abort in the same cycle: abort wins
    @(posedge clk);
    #2 start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    abort = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      seen += int'(busy) + int'(en);
    end
    check("start_abort_dropped", seen, 0);

    // Reset mid-image at pixel 500
    start_and_wait(500);
    #1 rst_n = 1'b0;
    mon_on = 1'b0;
    #1 check_reset_outputs("midimage_reset_outputs");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    run_image(100, -1, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/input_image_bram_reader.md
INPUT_IMAGE_BRAM_READER -- requirements
Module: input_image_bram_reader

Interface
REQ-001 Parameters (name, default, meaning): BASE_ADDR, 32'h0000_0000, byte address of image word 0; IMG_W, 28, pixels per row; IMG_H, 28, rows per image.
REQ-002 Derived constant NUM_WORDS = IMG_W*IMG_H/4 (196 at defaults); IMG_W*IMG_H SHALL be a multiple of 4.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  one-cycle request to stream one image.
REQ-006 abort  in  1  synchronous flush to IDLE.
REQ-007 busy  out  1  high from accepted start until done.
REQ-008 done  out  1  one-cycle pulse after the last pixel handshake.
REQ-009 BRAM_PORTB_0_clk  out  1  equals clk (pass-through).
REQ-010 BRAM_PORTB_0_addr  out  32  byte read address.
REQ-011 BRAM_PORTB_0_en  out  1  read enable.
REQ-012 BRAM_PORTB_0_we  out  4  constant 4'b0000.
REQ-013 BRAM_PORTB_0_din  out  32  constant 0.
REQ-014 BRAM_PORTB_0_dout  in  32  read data, valid exactly one cycle after en.
REQ-015 pix_data  out  8  pixel; pix_valid out 1; pix_ready in 1; pix_last out 1 (final pixel); row_last out 1 (column IMG_W-1).

Function
REQ-016 FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on handshake of pixel IMG_W*IMG_H-1; DONE->IDLE after one cycle with done=1.
REQ-017 start in RUN or DONE SHALL be ignored.
REQ-018 In RUN, word k read at address BASE_ADDR + 4*k, k = 0..NUM_WORDS-1, in order, each exactly once.
REQ-019 en SHALL assert only when FIFO occupancy plus in-flight reads < 2; never more than NUM_WORDS reads per image.
REQ-020 Returned word captured into 2-entry word FIFO the cycle after en; FIFO SHALL never overflow.
REQ-021 Unpacker emits byte 0 (dout[7:0]) first, byte 3 last; pops FIFO after byte 3 handshake.
REQ-022 pix_valid held with stable pix_data/pix_last/row_last until pix_ready; handshake = pix_valid & pix_ready.
REQ-023 With pix_ready held high, throughput SHALL be 1 pixel/cycle after first pixel; first pixel pix_valid no later than 3 cycles after start.
REQ-024 Column counter wraps 0..IMG_W-1; row counter 0..IMG_H-1; row_last when column = IMG_W-1; pix_last only on final pixel (also row_last).
REQ-025 abort (any state) SHALL next cycle: state IDLE, en=0, FIFO empty, counters 0, pix_valid=0, busy=0, no done pulse; an in-flight read return is discarded.
REQ-026 abort and start same cycle: abort wins, start dropped.
REQ-027 start accepted in cycle after DONE (IDLE) SHALL begin a new image from word 0.

Reset
REQ-028 rst_n low: state IDLE, busy=0, done=0, en=0, addr=BASE_ADDR, pix_valid=0, pix_data=0, pix_last=0, row_last=0, FIFO empty, counters 0.
REQ-029 Reset mid-image SHALL discard all progress; in-flight read data ignored after release.

Structure
REQ-030 cnn_mnist_pkg SHALL hold PIX_W=8, MNIST_IMG_W=28, MNIST_IMG_H=28, BRAM_WORD_BYTES=4, and the FSM state type.
REQ-031 One sub-module bram_rd_skid_fifo (2-entry, 32-bit, push/pop/full/empty/count); all else inline.

Verification
REQ-032 Model BRAM preloaded word k = {k[7:0]+3,k[7:0]+2,k[7:0]+1,k[7:0]}; start, pix_ready=1 -> 784 pixels in order 0,1,2,3,1,2,3,4...; pix_last on pixel 783 only; done at cycle after it.
REQ-033 pix_ready random 50% -> identical pixel sequence, no drops or repeats, max 2 words buffered, en count = 196.
REQ-034 pix_ready=0 for 100 cycles after start -> en asserted at most 2 times, pix_data stable, addr 0x0 then 0x4.
REQ-035 abort at pixel 300 -> next cycle busy=0, pix_valid=0, no done; new start streams from pixel 0 with addr 0x0.
REQ-036 rst_n low at pixel 500, release, start -> clean full image; row_last on pixels 27,55,...,783 (28 pulses).
REQ-037 start during RUN and start+abort same cycle -> ignored/dropped; busy and addr sequence unaffected.
